// File: rtl/dispatch_unit_mq_if.sv
// dispatch_unit_mq_if: IFQ, rename, CDB and issue-queue signals around the dispatch stage
interface dispatch_unit_mq_if #(
  parameter int NUM_INT = 2,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32
);
  logic [31:0] ifetch_intruction;
  logic [31:0] ifetch_pc_4;
  logic ifetch_empty;
  logic Dispatch_ren;
  logic Dispatch_jmp;
  logic [31:0] Dispatch_jmp_addr;
  logic tag_empty;
  logic [TAG_W-1:0] tag_in;
  logic rob_full;
  logic tag_ren;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic rs_ready;
  logic [DATA_W-1:0] rs_value;
  logic [TAG_W-1:0] rs_tag_in;
  logic rt_ready;
  logic [DATA_W-1:0] rt_value;
  logic [TAG_W-1:0] rt_tag_in;
  logic Cdb_valid;
  logic [TAG_W-1:0] Cdb_rd_tag;
  logic [DATA_W-1:0] Cdb_data;
  logic flush;
  logic [DATA_W-1:0] dispatch_rs_data;
  logic [DATA_W-1:0] dispatch_rt_data;
  logic dispatch_rs_data_valid;
  logic dispatch_rt_data_valid;
  logic [TAG_W-1:0] dispatch_rs_tag;
  logic [TAG_W-1:0] dispatch_rt_tag;
  logic [TAG_W-1:0] dispatch_rd_tag;
  logic [4:0] dispatch_rd_reg;
  logic [31:0] dispatch_pc;
  logic [NUM_INT-1:0] dispatch_en_integer;
  logic [NUM_INT-1:0] issueque_integer_full;
  logic [3:0] dispatch_opcode;
  logic [4:0] dispatch_shfamt;
  logic [31:0] dispatch_branch_addr;
  logic dispatch_en_ld_st;
  logic issueque_full_ld_st;
  logic dispatch_opcode_ld_st;
  logic [15:0] dispatch_imm_ld_st;
  logic dispatch_en_mul;
  logic issueque_mul_full;
  modport master (
    input ifetch_intruction, ifetch_pc_4, ifetch_empty, tag_empty, tag_in, rob_full,
    input rs_ready, rs_value, rs_tag_in, rt_ready, rt_value, rt_tag_in,
    input Cdb_valid, Cdb_rd_tag, Cdb_data, flush,
    input issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
    output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr, tag_ren, rs_addr, rt_addr,
    output dispatch_rs_data, dispatch_rt_data, dispatch_rs_data_valid, dispatch_rt_data_valid,
    output dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag, dispatch_rd_reg, dispatch_pc,
    output dispatch_en_integer, dispatch_opcode, dispatch_shfamt, dispatch_branch_addr,
    output dispatch_en_ld_st, dispatch_opcode_ld_st, dispatch_imm_ld_st, dispatch_en_mul
  );
  modport slave (
    output ifetch_intruction, ifetch_pc_4, ifetch_empty, tag_empty, tag_in, rob_full,
    output rs_ready, rs_value, rs_tag_in, rt_ready, rt_value, rt_tag_in,
    output Cdb_valid, Cdb_rd_tag, Cdb_data, flush,
    output issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
    input Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr, tag_ren, rs_addr, rt_addr,
    input dispatch_rs_data, dispatch_rt_data, dispatch_rs_data_valid, dispatch_rt_data_valid,
    input dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag, dispatch_rd_reg, dispatch_pc,
    input dispatch_en_integer, dispatch_opcode, dispatch_shfamt, dispatch_branch_addr,
    input dispatch_en_ld_st, dispatch_opcode_ld_st, dispatch_imm_ld_st, dispatch_en_mul
  );
endinterface

// File: rtl/dispatch_unit_mq.sv
// dispatch_unit_mq: in-order decode/rename/issue stage feeding integer, ld/st and mul queues
module dispatch_unit_mq #(
  parameter int NUM_INT = 2,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset,
  dispatch_unit_mq_if.master bus
);
  localparam int IW = NUM_INT > 1 ? $clog2(NUM_INT) : 1;
  logic [31:0] instr;
  logic [5:0] op;
  logic [5:0] funct;
  logic is_int;
  logic is_ldst;
  logic is_mul;
  logic is_j;
  logic queued;
  logic res_ok;
  logic accept;
  logic found;
  logic imm_rt;
  logic [3:0] opc;
  logic [4:0] rd;
  logic [IW-1:0] rr_last;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [NUM_INT-1:0] sel_oh;
  logic jmp_bubble;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_d;
  logic [DATA_W-1:0] rt_d;
  logic rs_v;
  logic rt_v;
  logic [TAG_W-1:0] rs_t;
  logic [TAG_W-1:0] rt_t;
  assign instr = bus.ifetch_intruction;
  assign op = instr[31:26];
  assign funct = instr[5:0];
  assign is_mul = op == 6'h00 && funct == 6'h18;
  assign is_ldst = op == 6'h23 || op == 6'h2B;
  assign is_j = op == 6'h02;
  assign queued = is_int | is_ldst | is_mul;
  always_comb begin
    is_int = 1'b1;
    opc = 4'd0;
    rd = instr[15:11];
    imm_rt = 1'b0;
    case (op)
      6'h00:
        case (funct)
          6'h20: opc = 4'd0;
          6'h22: opc = 4'd1;
          6'h24: opc = 4'd2;
          6'h25: opc = 4'd3;
          6'h2A: opc = 4'd4;
          6'h00: opc = 4'd5;
          6'h02: opc = 4'd6;
          default: is_int = 1'b0;
        endcase
      6'h08: begin opc = 4'd8; rd = instr[20:16]; imm_rt = 1'b1; end
      6'h0C: begin opc = 4'd9; rd = instr[20:16]; imm_rt = 1'b1; end
      6'h0D: begin opc = 4'd10; rd = instr[20:16]; imm_rt = 1'b1; end
      6'h04: begin opc = 4'd11; rd = 5'd0; end
      6'h23: begin is_int = 1'b0; rd = instr[20:16]; end
      default: begin is_int = 1'b0; rd = 5'd0; end
    endcase
  end
  always_comb begin
    found = 1'b0;
    sel = rr_last;
    idx = '0;
    for (int i = 1; i <= NUM_INT; i++) begin
      idx = IW'((int'(rr_last) + i) % NUM_INT);
      if (!found && !bus.issueque_integer_full[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    sel_oh = NUM_INT'(1) << sel;
  end
  assign imm_ext = op == 6'h08 ? {{(DATA_W-16){instr[15]}}, instr[15:0]} : {{(DATA_W-16){1'b0}}, instr[15:0]};
  assign rs_v = bus.rs_ready | (bus.Cdb_valid && bus.Cdb_rd_tag == bus.rs_tag_in);
  assign rs_d = bus.rs_ready ? bus.rs_value : rs_v ? bus.Cdb_data : '0;
  assign rs_t = rs_v ? '0 : bus.rs_tag_in;
  assign rt_v = imm_rt | bus.rt_ready | (bus.Cdb_valid && bus.Cdb_rd_tag == bus.rt_tag_in);
  assign rt_d = imm_rt ? imm_ext : bus.rt_ready ? bus.rt_value : rt_v ? bus.Cdb_data : '0;
  assign rt_t = rt_v ? '0 : bus.rt_tag_in;
  assign res_ok = !bus.tag_empty && !bus.rob_full && (is_int ? found : is_ldst ? !bus.issueque_full_ld_st : !bus.issueque_mul_full);
  assign accept = !reset && !bus.ifetch_empty && !bus.flush && !jmp_bubble && (!queued || res_ok);
  assign bus.Dispatch_ren = accept;
  assign bus.tag_ren = accept & queued;
  assign bus.rs_addr = instr[25:21];
  assign bus.rt_addr = instr[20:16];
  assign bus.Dispatch_jmp = jmp_bubble;
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.dispatch_en_integer <= '0;
      bus.dispatch_en_ld_st <= 1'b0;
      bus.dispatch_en_mul <= 1'b0;
      jmp_bubble <= 1'b0;
      bus.Dispatch_jmp_addr <= '0;
      rr_last <= IW'(NUM_INT - 1);
      bus.dispatch_rs_data <= '0;
      bus.dispatch_rt_data <= '0;
      bus.dispatch_rs_data_valid <= 1'b0;
      bus.dispatch_rt_data_valid <= 1'b0;
      bus.dispatch_rs_tag <= '0;
      bus.dispatch_rt_tag <= '0;
      bus.dispatch_rd_tag <= '0;
      bus.dispatch_rd_reg <= '0;
      bus.dispatch_pc <= '0;
      bus.dispatch_opcode <= '0;
      bus.dispatch_shfamt <= '0;
      bus.dispatch_branch_addr <= '0;
      bus.dispatch_opcode_ld_st <= 1'b0;
      bus.dispatch_imm_ld_st <= '0;
    end else begin
      bus.dispatch_en_integer <= accept && is_int ? sel_oh : '0;
      bus.dispatch_en_ld_st <= accept & is_ldst;
      bus.dispatch_en_mul <= accept & is_mul;
      jmp_bubble <= accept & is_j;
      if (accept && is_j)
        bus.Dispatch_jmp_addr <= {bus.ifetch_pc_4[31:28], instr[25:0], 2'b00};
      if (accept && is_int)
        rr_last <= sel;
      if (accept && queued) begin
        bus.dispatch_rs_data <= rs_d;
        bus.dispatch_rt_data <= rt_d;
        bus.dispatch_rs_data_valid <= rs_v;
        bus.dispatch_rt_data_valid <= rt_v;
        bus.dispatch_rs_tag <= rs_t;
        bus.dispatch_rt_tag <= rt_t;
        bus.dispatch_rd_tag <= bus.tag_in;
        bus.dispatch_rd_reg <= rd;
        bus.dispatch_pc <= bus.ifetch_pc_4;
        bus.dispatch_opcode <= opc;
        bus.dispatch_shfamt <= instr[10:6];
        bus.dispatch_branch_addr <= bus.ifetch_pc_4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        bus.dispatch_opcode_ld_st <= op == 6'h2B;
        bus.dispatch_imm_ld_st <= instr[15:0];
      end
    end
  end
endmodule

// File: doc/dispatch_unit_mq.md
# dispatch_unit_mq

Next-generation in-order dispatch stage for the out-of-order MIPS core. It sits between the IFQ and the issue queues. Each cycle it accepts at most one instruction, decodes it and allocates a tag/ROB entry. Operands come from the rename lookup, with same-cycle CDB forwarding. It then issues the instruction to one of `NUM_INT` integer queues (round-robin, skipping full queues), the LD/ST queue or the MUL queue, and executes J itself.

## Interface
- `NUM_INT`, 2, number of integer issue queues (1..4).
- `TAG_W`, 5, tag width.
- `DATA_W`, 32, operand width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ifetch_intruction` in 32; `ifetch_pc_4` in 32; `ifetch_empty` in 1 (1 = no instruction); `Dispatch_ren` out 1 (pops the IFQ this cycle).
- `Dispatch_jmp` out 1; `Dispatch_jmp_addr` out 32: jump redirect.
- `tag_empty` in 1; `tag_in` in TAG_W; `rob_full` in 1; `tag_ren` out 1: allocates tag and ROB entry (same cycle as `Dispatch_ren`).
- `rs_addr`, `rt_addr` out 5: combinational, `instr[25:21]` and `instr[20:16]`.
- `rs_ready` in 1; `rs_value` in DATA_W; `rs_tag_in` in TAG_W; `rt_ready`, `rt_value`, `rt_tag_in`: rename lookup results, same cycle.
- `Cdb_valid` in 1; `Cdb_rd_tag` in TAG_W; `Cdb_data` in DATA_W; `flush` in 1.
- `dispatch_rs_data`, `dispatch_rt_data` out DATA_W; `dispatch_rs_data_valid`, `dispatch_rt_data_valid` out 1; `dispatch_rs_tag`, `dispatch_rt_tag`, `dispatch_rd_tag` out TAG_W; `dispatch_rd_reg` out 5; `dispatch_pc` out 32.
- `dispatch_en_integer` out NUM_INT (one-hot); `issueque_integer_full` in NUM_INT; `dispatch_opcode` out 4; `dispatch_shfamt` out 5; `dispatch_branch_addr` out 32.
- `dispatch_en_ld_st` out 1; `issueque_full_ld_st` in 1; `dispatch_opcode_ld_st` out 1 (0 = LW, 1 = SW); `dispatch_imm_ld_st` out 16.
- `dispatch_en_mul` out 1; `issueque_mul_full` in 1.

## Operation
- **Decode, R-type (op 0):**
  - funct 0x20 → opcode 0 (ADD); 0x22 → 1 (SUB); 0x24 → 2 (AND); 0x25 → 3 (OR); 0x2A → 4 (SLT); 0x00 → 5 (SLL); 0x02 → 6 (SRL).
  - These all go to an integer queue with rd = `instr[15:11]`.
  - funct 0x18 (MULT) goes to the MUL queue.
- **Decode, I-type:**
  - ADDI 0x08 → opcode 8; ANDI 0x0C → 9; ORI 0x0D → 10. Integer queue, rd = rt. `dispatch_rt_data` = imm (sign-extended for ADDI, zero-extended for ANDI/ORI) with `rt_valid` = 1 and `rt_tag` = 0.
  - LW 0x23 and SW 0x2B go to LD/ST with imm = `instr[15:0]`.
  - BEQ 0x04 → opcode 11, integer queue. `dispatch_branch_addr` = pc_4 + (sext(imm) << 2), modulo 2^32. `dispatch_rd_reg` = 0.
- **J 0x02:** no tag, no queue. Target = {pc_4[31:28], instr[25:0], 2'b00}.
- **Any other opcode:** NOP. It is consumed, with no tag and no enable.
- **Accept condition:** !`ifetch_empty` & !`flush` & !`jmp_bubble` & resources free.
  - Queued classes need !`tag_empty` & !`rob_full` & the target queue not full. For integer this means at least one bit of `issueque_integer_full` is 0.
  - On accept, `Dispatch_ren` = 1. `tag_ren` = 1 for queued classes only.
  - Otherwise the block stalls and the IFQ holds the instruction.
- **Integer queue selection:** scan indices `rr_last`+1 … `rr_last`+NUM_INT, mod NUM_INT. Pick the first queue not full. `rr_last` updates to the chosen index on each integer accept. Reset value of `rr_last` is NUM_INT-1, so queue 0 is picked first.
- **Operand capture, rs and rt independently:**
  - If ready, take value, valid = 1, tag = 0.
  - Else if `Cdb_valid` and `Cdb_rd_tag` == lookup tag, take `Cdb_data`, valid = 1.
  - Else data = 0, valid = 0, tag = lookup tag.
- **Jump:** accepting J sets `jmp_bubble` for one cycle. During that cycle `Dispatch_jmp` = 1, `Dispatch_jmp_addr` holds the target, and accept is blocked.
- **Flush:** while `flush` = 1 there is no accept. All enable and `Dispatch_jmp` registers clear on the next edge, and `jmp_bubble` clears.

## Timing
- `Dispatch_ren`, `tag_ren`, `rs_addr` and `rt_addr` are combinational in accept cycle N.
- All `dispatch_*` payload, the enables and `Dispatch_jmp` are registered. They are valid in cycle N+1 only; enables are one-cycle pulses. Back-to-back accepts give enables on consecutive cycles.
- Payload holds its last value when no enable is asserted.
- Reset: all enables 0, `Dispatch_jmp` 0, `Dispatch_jmp_addr` 0, all payload 0, `jmp_bubble` 0. `Dispatch_ren` and `tag_ren` are 0 during reset.
- Queue-full flags are sampled in cycle N. A queue going full in N+1 does not cancel the pulse; each queue is required to keep one free slot of slack.
- Reset asserted mid-operation kills any pending pulse on that edge.

## Test plan
- **ADD then SUB, both int queues empty, NUM_INT = 2:** `dispatch_en_integer` = 01 then 10. Opcodes 0 then 1. Tags equal successive `tag_in` values. `Dispatch_ren` high both cycles.
- **`issueque_integer_full` = 01 with three ADDs:** all three go to queue 1 (10, 10, 10). Releasing queue 0 makes the next ADD select 01.
- **LW x1, 8(x2) with rs not ready, `rs_tag_in` = 7, same-cycle CDB tag 7 data 0x55:** `dispatch_en_ld_st` = 1, `rs_data` = 0x55, valid = 1, imm = 8, `opcode_ld_st` = 0.
- **J 0x0000040 at pc_4 0x10000004:** next cycle `Dispatch_jmp` = 1 and addr = 0x10000100. Accept is blocked that cycle and `tag_ren` stays 0.
- **`tag_empty` = 1 with a valid MULT:** `Dispatch_ren` = 0 and no enable. Dropping `tag_empty` dispatches with `dispatch_en_mul` = 1 one cycle later.
- **Flush in the cycle after an accept, and reset during a stall:** no accept during flush, no `Dispatch_jmp`. After reset all outputs are 0 and the first integer pick is queue 0.
